// File: rtl/id_ex_operand_stage_pkg.sv
// Shared constants for the ID/EX operand stage.
// Default widths, the zero register index and the control bubble.
package id_ex_operand_stage_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CTRL_W     = 16;

  localparam logic [DEF_REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam logic [DEF_CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_operand_stage_operand_bypass_mux.sv
// Single-source operand resolution: r0, then MEM, then WB, then RF.
// WB bypass exists because the RF commits on the same clk edge.
module operand_bypass_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic                  mem_fwd_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_write_register,
  input  logic [DATA_W-1:0]     wb_write_data,
  output logic [DATA_W-1:0]     operand
);

  always_comb begin
    operand = rf_data;
    if (src == REG_ADDR_W'(REG_ZERO)) begin
      operand = '0;
    end else if (mem_fwd_en && mem_dest == src) begin
      operand = mem_data;
    end else if (wb_reg_write &&
                 wb_write_register == src) begin
      operand = wb_write_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: bypass, load-use hazard, pipeline register.
// Optional OPF_STALL_CNT_EN adds a hazard-stall cycle counter.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CTRL_W     = DEF_CTRL_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rt,
  input  logic                  i_use_rs,
  input  logic                  i_use_rt,
  input  logic [REG_ADDR_W-1:0] i_dest,
  input  logic [DATA_W-1:0]     i_imm,
  input  logic [CTRL_W-1:0]     i_ctrl,
  input  logic                  i_mem_read,
  input  logic [DATA_W-1:0]     i_rf_data1,
  input  logic [DATA_W-1:0]     i_rf_data2,
  input  logic                  i_mem_fwd_en,
  input  logic                  i_mem_load_pending,
  input  logic [REG_ADDR_W-1:0] i_mem_dest,
  input  logic [DATA_W-1:0]     i_mem_data,
  input  logic                  i_wb_reg_write,
  input  logic [REG_ADDR_W-1:0] i_wb_write_register,
  input  logic [DATA_W-1:0]     i_wb_write_data,
  input  logic                  i_ex_stall,
  input  logic                  i_flush,
  output logic                  o_id_stall,
  output logic                  o_ex_valid,
  output logic [DATA_W-1:0]     o_ex_rs_data,
  output logic [DATA_W-1:0]     o_ex_rt_data,
  output logic [DATA_W-1:0]     o_ex_imm,
  output logic [REG_ADDR_W-1:0] o_ex_dest,
  output logic [CTRL_W-1:0]     o_ex_ctrl,
`ifdef OPF_STALL_CNT_EN
  output logic                  o_ex_mem_read,
  output logic [31:0]           o_stall_count
`else
  output logic                  o_ex_mem_read
`endif
);

  localparam logic [REG_ADDR_W-1:0] RZ =
    REG_ADDR_W'(REG_ZERO);
  localparam logic [CTRL_W-1:0] CB =
    CTRL_W'(CTRL_BUBBLE);

  logic [DATA_W-1:0] rs_op;
  logic [DATA_W-1:0] rt_op;
  logic              rs_match;
  logic              rt_match;
  logic              hz;

  operand_bypass_mux #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_rs_mux (
    .src               (i_rs),
    .rf_data           (i_rf_data1),
    .mem_fwd_en        (i_mem_fwd_en),
    .mem_dest          (i_mem_dest),
    .mem_data          (i_mem_data),
    .wb_reg_write      (i_wb_reg_write),
    .wb_write_register (i_wb_write_register),
    .wb_write_data     (i_wb_write_data),
    .operand           (rs_op)
  );

  operand_bypass_mux #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_rt_mux (
    .src               (i_rt),
    .rf_data           (i_rf_data2),
    .mem_fwd_en        (i_mem_fwd_en),
    .mem_dest          (i_mem_dest),
    .mem_data          (i_mem_data),
    .wb_reg_write      (i_wb_reg_write),
    .wb_write_register (i_wb_write_register),
    .wb_write_data     (i_wb_write_data),
    .operand           (rt_op)
  );

  // A load in EX or a still-pending load in MEM cannot be bypassed.
  always_comb begin
    rs_match =
      (o_ex_valid && o_ex_mem_read && o_ex_dest == i_rs) ||
      (i_mem_load_pending && i_mem_dest == i_rs);
    rt_match =
      (o_ex_valid && o_ex_mem_read && o_ex_dest == i_rt) ||
      (i_mem_load_pending && i_mem_dest == i_rt);
    hz = i_id_valid &&
         ((i_use_rs && i_rs != RZ && rs_match) ||
          (i_use_rt && i_rt != RZ && rt_match));
    o_id_stall = !i_flush && (i_ex_stall || hz);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_ex_valid    <= 1'b0;
      o_ex_rs_data  <= '0;
      o_ex_rt_data  <= '0;
      o_ex_imm      <= '0;
      o_ex_dest     <= '0;
      o_ex_ctrl     <= '0;
      o_ex_mem_read <= 1'b0;
    end else if (i_flush || (!i_ex_stall && hz)) begin
      o_ex_valid    <= 1'b0;
      o_ex_rs_data  <= '0;
      o_ex_rt_data  <= '0;
      o_ex_imm      <= '0;
      o_ex_dest     <= RZ;
      o_ex_ctrl     <= CB;
      o_ex_mem_read <= 1'b0;
    end else if (!i_ex_stall) begin
      o_ex_valid    <= i_id_valid;
      o_ex_rs_data  <= rs_op;
      o_ex_rt_data  <= rt_op;
      o_ex_imm      <= i_imm;
      o_ex_dest     <= i_id_valid ? i_dest : RZ;
      o_ex_ctrl     <= i_id_valid ? i_ctrl : CB;
      o_ex_mem_read <= i_id_valid && i_mem_read;
    end
  end

`ifdef OPF_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_stall_count <= '0;
    end else if (hz && !i_ex_stall && !i_flush) begin
      o_stall_count <= o_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage.
// Covers bypass priority, r0, load-use, stall/flush and async reset.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_id_valid;
  logic [4:0]  i_rs, i_rt, i_dest;
  logic        i_use_rs, i_use_rt;
  logic [31:0] i_imm;
  logic [15:0] i_ctrl;
  logic        i_mem_read;
  logic [31:0] i_rf_data1, i_rf_data2;
  logic        i_mem_fwd_en, i_mem_load_pending;
  logic [4:0]  i_mem_dest;
  logic [31:0] i_mem_data;
  logic        i_wb_reg_write;
  logic [4:0]  i_wb_write_register;
  logic [31:0] i_wb_write_data;
  logic        i_ex_stall, i_flush;
  logic        o_id_stall, o_ex_valid;
  logic [31:0] o_ex_rs_data, o_ex_rt_data, o_ex_imm;
  logic [4:0]  o_ex_dest;
  logic [15:0] o_ex_ctrl;
  logic        o_ex_mem_read;
`ifdef OPF_STALL_CNT_EN
  logic [31:0] o_stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .i_id_valid          (i_id_valid),
    .i_rs                (i_rs),
    .i_rt                (i_rt),
    .i_use_rs            (i_use_rs),
    .i_use_rt            (i_use_rt),
    .i_dest              (i_dest),
    .i_imm               (i_imm),
    .i_ctrl              (i_ctrl),
    .i_mem_read          (i_mem_read),
    .i_rf_data1          (i_rf_data1),
    .i_rf_data2          (i_rf_data2),
    .i_mem_fwd_en        (i_mem_fwd_en),
    .i_mem_load_pending  (i_mem_load_pending),
    .i_mem_dest          (i_mem_dest),
    .i_mem_data          (i_mem_data),
    .i_wb_reg_write      (i_wb_reg_write),
    .i_wb_write_register (i_wb_write_register),
    .i_wb_write_data     (i_wb_write_data),
    .i_ex_stall          (i_ex_stall),
    .i_flush             (i_flush),
    .o_id_stall          (o_id_stall),
    .o_ex_valid          (o_ex_valid),
    .o_ex_rs_data        (o_ex_rs_data),
    .o_ex_rt_data        (o_ex_rt_data),
    .o_ex_imm            (o_ex_imm),
    .o_ex_dest           (o_ex_dest),
    .o_ex_ctrl           (o_ex_ctrl),
`ifdef OPF_STALL_CNT_EN
    .o_ex_mem_read       (o_ex_mem_read),
    .o_stall_count       (o_stall_count)
`else
    .o_ex_mem_read       (o_ex_mem_read)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic quiet();
    i_id_valid = 0; i_rs = 0; i_rt = 0;
    i_use_rs = 0; i_use_rt = 0; i_dest = 0;
    i_imm = 0; i_ctrl = 0; i_mem_read = 0;
    i_rf_data1 = 0; i_rf_data2 = 0;
    i_mem_fwd_en = 0; i_mem_load_pending = 0;
    i_mem_dest = 0; i_mem_data = 0;
    i_wb_reg_write = 0; i_wb_write_register = 0;
    i_wb_write_data = 0;
    i_ex_stall = 0; i_flush = 0;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    quiet();
    reset = 1;
    #2;
    chk("rst_valid", 32'(o_ex_valid), 0);
    chk("rst_ctrl", 32'(o_ex_ctrl), 0);
    chk("rst_rs", o_ex_rs_data, 0);
    chk("rst_stall", 32'(o_id_stall), 0);
    @(negedge clk);
    reset = 0;

    // WB bypass over RF
    i_id_valid = 1; i_rs = 8; i_use_rs = 1;
    i_rf_data1 = 32'h11; i_wb_reg_write = 1;
    i_wb_write_register = 8;
    i_wb_write_data = 32'hABCD;
    i_dest = 3; i_imm = 32'h100; i_ctrl = 16'h00A5;
    #1;
    chk("wb_stall", 32'(o_id_stall), 0);
    edge1();
    chk("wb_rs", o_ex_rs_data, 32'hABCD);
    chk("wb_valid", 32'(o_ex_valid), 1);
    chk("wb_imm", o_ex_imm, 32'h100);
    chk("wb_dest", 32'(o_ex_dest), 3);
    chk("wb_ctrl", 32'(o_ex_ctrl), 32'h00A5);

    // MEM beats WB
    @(negedge clk);
    quiet();
    i_id_valid = 1; i_rt = 8; i_use_rt = 1;
    i_rf_data2 = 32'h99;
    i_mem_fwd_en = 1; i_mem_dest = 8; i_mem_data = 5;
    i_wb_reg_write = 1; i_wb_write_register = 8;
    i_wb_write_data = 7;
    i_rf_data1 = 32'h1234;
    edge1();
    chk("memwb_rt", o_ex_rt_data, 5);
    chk("memwb_rs0", o_ex_rs_data, 0);

    // r0 never forwarded, never hazards
    @(negedge clk);
    quiet();
    i_id_valid = 1; i_rs = 0; i_use_rs = 1;
    i_rf_data1 = 32'h77;
    i_mem_fwd_en = 1; i_mem_dest = 0;
    i_mem_data = 32'hFFFF; i_mem_load_pending = 1;
    #1;
    chk("r0_stall", 32'(o_id_stall), 0);
    edge1();
    chk("r0_rs", o_ex_rs_data, 0);
    chk("r0_valid", 32'(o_ex_valid), 1);

    // load-use: lw r9 then use r9
    @(negedge clk);
    quiet();
    i_id_valid = 1; i_rs = 1; i_use_rs = 1;
    i_dest = 9; i_mem_read = 1; i_ctrl = 16'h0003;
    edge1();
    chk("lw_mr", 32'(o_ex_mem_read), 1);
    chk("lw_dest", 32'(o_ex_dest), 9);
    @(negedge clk);
    quiet();
    i_id_valid = 1; i_rs = 9; i_use_rs = 1;
    i_dest = 4; i_rf_data1 = 32'h77; i_ctrl = 16'h0001;
    #1;
    chk("lu_stall", 32'(o_id_stall), 1);
    edge1();
    chk("lu_bub_valid", 32'(o_ex_valid), 0);
    chk("lu_bub_ctrl", 32'(o_ex_ctrl), 0);
    chk("lu_bub_dest", 32'(o_ex_dest), 0);
    chk("lu_unstall", 32'(o_id_stall), 0);
    @(negedge clk);
    i_mem_fwd_en = 1; i_mem_dest = 9; i_mem_data = 32'h42;
    edge1();
    chk("lu_fwd_rs", o_ex_rs_data, 32'h42);
    chk("lu_fwd_valid", 32'(o_ex_valid), 1);
    chk("lu_fwd_dest", 32'(o_ex_dest), 4);

    // EX stall holds even with hazard; flush beats stall
    @(negedge clk);
    quiet();
    i_id_valid = 1; i_rs = 2; i_use_rs = 1;
    i_rf_data1 = 32'h33; i_dest = 9; i_mem_read = 1;
    i_ctrl = 16'h1234;
    edge1();
    @(negedge clk);
    quiet();
    i_id_valid = 1; i_rs = 9; i_use_rs = 1;
    i_rf_data1 = 32'h66; i_dest = 5; i_ctrl = 16'h0F0F;
    i_ex_stall = 1;
    #1;
    chk("st_stall", 32'(o_id_stall), 1);
    edge1();
    chk("st_valid", 32'(o_ex_valid), 1);
    chk("st_dest", 32'(o_ex_dest), 9);
    chk("st_ctrl", 32'(o_ex_ctrl), 32'h1234);
    chk("st_rs", o_ex_rs_data, 32'h33);
    @(negedge clk);
    i_flush = 1;
    #1;
    chk("fl_stall", 32'(o_id_stall), 0);
    edge1();
    chk("fl_valid", 32'(o_ex_valid), 0);
    chk("fl_ctrl", 32'(o_ex_ctrl), 0);
    chk("fl_dest", 32'(o_ex_dest), 0);

    // invalid decode zeroes ctrl/dest/mem_read
    @(negedge clk);
    quiet();
    i_ctrl = 16'hFFFF; i_dest = 7; i_mem_read = 1;
    edge1();
    chk("inv_valid", 32'(o_ex_valid), 0);
    chk("inv_ctrl", 32'(o_ex_ctrl), 0);
    chk("inv_dest", 32'(o_ex_dest), 0);
    chk("inv_mr", 32'(o_ex_mem_read), 0);

    // async reset between edges
    @(negedge clk);
    quiet();
    i_id_valid = 1; i_rs = 5; i_use_rs = 1;
    i_rf_data1 = 32'h55; i_dest = 6; i_ctrl = 16'h000F;
    i_imm = 32'h8;
    edge1();
    chk("pre_rst_rs", o_ex_rs_data, 32'h55);
    #2;
    reset = 1;
    #1;
    chk("ar_valid", 32'(o_ex_valid), 0);
    chk("ar_rs", o_ex_rs_data, 0);
    chk("ar_imm", o_ex_imm, 0);
    chk("ar_ctrl", 32'(o_ex_ctrl), 0);
    chk("ar_dest", 32'(o_ex_dest), 0);
`ifdef OPF_STALL_CNT_EN
    chk("ar_cnt", o_stall_count, 0);
`endif
    quiet();
    #1;
    chk("ar_stall", 32'(o_id_stall), 0);
    @(negedge clk);
    reset = 0;

    // MEM pending load holds decode for 3 cycles
    i_id_valid = 1; i_rs = 9; i_use_rs = 1;
    i_mem_load_pending = 1; i_mem_dest = 9;
    repeat (3) edge1();
    chk("pend_stall", 32'(o_id_stall), 1);
    chk("pend_valid", 32'(o_ex_valid), 0);
`ifdef OPF_STALL_CNT_EN
    chk("pend_cnt", o_stall_count, 3);
`endif
    @(negedge clk);
    i_mem_load_pending = 0;
    #1;
    chk("pend_clear", 32'(o_id_stall), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
Decode-to-execute operand stage, directly downstream of the register file read ports.
- Resolves final rs/rt operand values by bypassing in-flight MEM results and same-cycle WB writes over the raw register-file read data.
- Detects load-use hazards and backpressures decode.
- Latches the resolved instruction into the ID/EX pipeline register, with hold, bubble and flush control.

Parameters:
DATA_W, 32, operand/immediate width
REG_ADDR_W, 5, register index width
CTRL_W, 16, opaque decoded-control bundle width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
i_id_valid  input  1  decode holds a valid instruction
i_rs, i_rt  input  REG_ADDR_W  source register indices
i_use_rs, i_use_rt  input  1  instruction actually reads rs/rt
i_dest  input  REG_ADDR_W  destination register (0 = none)
i_imm  input  DATA_W  extended immediate
i_ctrl  input  CTRL_W  decoded control bundle
i_mem_read  input  1  instruction is a load
i_rf_data1, i_rf_data2  input  DATA_W  register-file read data for rs/rt
i_mem_fwd_en  input  1  MEM stage result valid and writes a register
i_mem_load_pending  input  1  MEM stage holds a load whose data is not yet available
i_mem_dest  input  REG_ADDR_W  MEM stage destination
i_mem_data  input  DATA_W  MEM stage result
i_wb_reg_write  input  1  WB write enable (same signal as the register-file write port)
i_wb_write_register  input  REG_ADDR_W  WB destination
i_wb_write_data  input  DATA_W  WB data
i_ex_stall  input  1  EX cannot accept; hold register
i_flush  input  1  discard decode instruction; bubble into EX
o_id_stall  output  1  decode must hold its instruction
o_ex_valid  output  1  ID/EX register valid
o_ex_rs_data, o_ex_rt_data  output  DATA_W  resolved operands
o_ex_imm  output  DATA_W  latched immediate
o_ex_dest  output  REG_ADDR_W  latched destination
o_ex_ctrl  output  CTRL_W  latched control
o_ex_mem_read  output  1  latched load flag

Behaviour:
Reset:
- Asynchronous, active-high.
- All outputs and registers go to 0, including o_ex_valid=0 and o_ex_ctrl=0.

Operand resolution (combinational, per source; shown for rs, rt identical):
- If i_rs==0: operand = 0.
- Else if i_mem_fwd_en && i_mem_dest==i_rs: operand = i_mem_data.
- Else if i_wb_reg_write && i_wb_write_register==i_rs: operand = i_wb_write_data.
- Else: operand = i_rf_data1.
- Priority is MEM > WB > RF. This is required because the register file commits on the clk edge, so a same-cycle WB write is not yet visible on its read port.

Hazard (combinational):
- hz = i_id_valid && ((i_use_rs && i_rs!=0 && match(i_rs)) || (i_use_rt && i_rt!=0 && match(i_rt))).
- match(r) = (o_ex_valid && o_ex_mem_read && o_ex_dest==r) || (i_mem_load_pending && i_mem_dest==r).
- o_id_stall = !i_flush && (i_ex_stall || hz).

ID/EX register update on posedge clk, in priority order:
1. i_flush: load a bubble (valid=0, ctrl=0, mem_read=0, dest=0); data fields don't-care but zeroed. Flush overrides i_ex_stall.
2. i_ex_stall: hold all fields unchanged. No bubble is inserted even if hz.
3. hz: load a bubble.
4. Otherwise: load resolved operands, i_imm, i_dest, i_ctrl, i_mem_read; valid = i_id_valid. If i_id_valid=0, ctrl, mem_read and dest are zeroed.

Latency and boundaries:
- Latency is one cycle from decode to EX.
- A load followed immediately by a use gives exactly 1 bubble; the MEM-stage pending load adds 1 more bubble if still pending.
- dest=0 never triggers forwarding or hazard.
- Reset in mid-stall clears the register and deasserts o_id_stall once inputs are quiet.

Optional Feature:
Macro OPF_STALL_CNT_EN.
- Defined: adds output o_stall_count [31:0], incremented each cycle hz && !i_ex_stall && !i_flush. It wraps at 2^32 and resets to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds: DATA_W, REG_ADDR_W, CTRL_W defaults; REG_ZERO=5'd0; a bubble constant for the ctrl bundle.
- One natural sub-module, operand_bypass_mux (single-source resolution), instantiated twice.

Test Plan:
- WB bypass: RF data1=0x11, WB writes r8=0xABCD same cycle, i_rs=8 -> o_ex_rs_data=0xABCD next cycle.
- MEM over WB: MEM r8=0x5, WB r8=0x7, i_rt=8 -> o_ex_rt_data=0x5.
- r0 protection: i_rs=0, MEM dest=0, data 0xFFFF -> o_ex_rs_data=0, o_id_stall=0.
- Load-use: EX holds lw to r9, decode uses r9 -> o_id_stall=1 for 1 cycle, o_ex_valid=0 bubble. Next cycle, with MEM forwarding r9=0x42, latch 0x42.
- Stall/flush priority: i_ex_stall=1 with hz=1 -> register held, o_id_stall=1. Then assert i_flush with i_ex_stall -> o_ex_valid=0, o_id_stall=0.
- Async reset mid-operation: assert reset between edges -> all outputs 0 immediately. With OPF_STALL_CNT_EN, o_stall_count=0, then counts 3 after 3 hazard cycles.
